jtag_ir_ctrl: RTL
=================

JTAG_IR_CTRL -- requirements
Module: jtag_ir_ctrl

Interface
REQ-001 Parameter: IR_WIDTH, default 4, instruction register length in bits; minimum 2.
REQ-002 Parameter: IDCODE_OP, default 4'b0001 (IR_WIDTH bits), opcode loaded at reset.
REQ-003 Parameter: READ_OP, default 4'b0010, read-data opcode.
REQ-004 Parameter: WRITE_OP, default 4'b0100, write-data opcode.
REQ-005 Parameter: CAPTURE_VAL, default 4'b0001, value loaded in Capture-IR; bits [1:0] shall be 2'b01.
REQ-006 Parameter: BYPASS opcode is not a parameter; it is fixed at all-ones.
REQ-007 Port: tck, input, 1, sole clock; all state changes on the rising edge.
REQ-008 Port: trst, input, 1, asynchronous active-low reset.
REQ-009 Port: tms, input, 1, TAP mode select, sampled on the rising edge of tck.
REQ-010 Port: tdi, input, 1, serial data in.
REQ-011 Port: ir_tdo, output, 1, IR serial out; equals shift_reg[0].
REQ-012 Port: ir_tdo_en, output, 1, high only in Shift-IR.
REQ-013 Port: instruction, output, IR_WIDTH, active (updated) instruction.
REQ-014 Port: sel_bypass, sel_idcode, sel_read, sel_write, output, 1 each, one-hot instruction decode.
REQ-015 Port: tap_state, output, 4, current TAP state code.
REQ-016 Port: dr_capture, dr_shift, dr_update, output, 1 each, high while in Capture-DR, Shift-DR or Update-DR respectively.

Function
REQ-017 The TAP state register shall implement the 16-state IEEE 1149.1 controller, advancing on each rising edge of tck according to tms.
REQ-018 State codes shall be as follows.
- TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpDR 5
- SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpIR D
REQ-019 Transitions shall be as follows (tms=0 / tms=1).
- TLR: RTI/TLR; RTI: RTI/SelDR; SelDR: CapDR/SelIR; SelIR: CapIR/TLR
- Cap: Sh/Ex1; Sh: Sh/Ex1; Ex1: Pause/Up; Pause: Pause/Ex2; Ex2: Sh/Up; Up: RTI/SelDR
- The Cap, Sh, Ex1, Pause, Ex2 and Up rows apply to both the DR and IR columns.
REQ-020 Five consecutive edges with tms=1 shall reach TLR from any state.
REQ-021 On an edge while in CapIR, shift_reg shall load CAPTURE_VAL.
REQ-022 On an edge while in ShIR, shift_reg shall become {tdi, shift_reg[IR_WIDTH-1:1]}, shifting LSB first; this applies on the exit edge to Ex1IR as well.
REQ-023 In all other states, shift_reg shall hold its value, including through PauseIR and Ex2IR.
REQ-024 On an edge while in UpIR, instruction shall load shift_reg; it shall not change at any other time except as required by REQ-025 and REQ-029.
REQ-025 On an edge while in TLR, instruction shall load IDCODE_OP synchronously.
REQ-026 Decode shall be combinational from instruction.
- sel_idcode = (instruction==IDCODE_OP); sel_read = (instruction==READ_OP); sel_write = (instruction==WRITE_OP)
- sel_bypass = 1 for the all-ones opcode and for any undefined opcode
- Exactly one sel_* shall be high at all times.
REQ-027 ir_tdo_en, dr_capture, dr_shift and dr_update shall be decoded combinationally from the registered state only, with no dependence on tms.
REQ-028 Elaboration shall fail if IR_WIDTH<2, if any two opcodes are equal, if any opcode is all-ones, or if CAPTURE_VAL[1:0]!=2'b01.

Reset
REQ-029 trst=0 shall immediately, without a tck edge, force the following.
- tap_state = F
- instruction = IDCODE_OP, so sel_idcode = 1
- shift_reg = CAPTURE_VAL
- all strobes and ir_tdo_en = 0
REQ-030 Assertion of trst mid-shift shall discard the partial shift, and instruction shall not take the partial value.
REQ-031 On trst release, the first rising edge of tck shall be evaluated normally from TLR.

Verification
REQ-032 Reset: pulse trst low during ShIR with instruction=WRITE_OP -> tap_state=F, instruction=0001 and sel_idcode=1 before the next tck edge.
REQ-033 IR load: from RTI, drive tms 1,1,0,0 then shift tdi 0,0,1,0 with tms 0,0,0,1, then tms 1,0 -> ir_tdo sequence 1,0,0,0; instruction=0100 and sel_write=1 after UpIR; back in RTI (C).
REQ-034 TLR recovery: from PauseDR, five edges with tms=1 -> tap_state=F; after one more edge with tms=1, instruction=IDCODE_OP.
REQ-035 Undefined opcode: load 0110 -> sel_bypass=1 and all other sel_* = 0; load 1111 -> sel_bypass=1.
REQ-036 Pause: shift 2 bits, go to PauseIR for 5 edges, return via Ex2IR and shift 2 more bits -> instruction unchanged until UpIR, then equals all 4 shifted bits.
REQ-037 Parametric: IR_WIDTH=8, IDCODE_OP=8'h01 -> 8-bit shift yields correct instruction; capture shows CAPTURE_VAL LSB-first on ir_tdo.

Source files
------------

// File: rtl/jtag_ir_ctrl_if.sv
// Serial TAP pins and instruction-register status outputs of jtag_ir_ctrl.
// master is the TAP driver side, slave is the controller.
interface jtag_ir_ctrl_if #(
  parameter int IR_WIDTH = 4
);
  logic                tms;
  logic                tdi;
  logic                ir_tdo;
  logic                ir_tdo_en;
  logic [IR_WIDTH-1:0] instruction;
  logic                sel_bypass;
  logic                sel_idcode;
  logic                sel_read;
  logic                sel_write;
  logic [3:0]          tap_state;
  logic                dr_capture;
  logic                dr_shift;
  logic                dr_update;

  modport master (
    output tms, tdi,
    input  ir_tdo, ir_tdo_en, instruction,
    input  sel_bypass, sel_idcode, sel_read, sel_write,
    input  tap_state, dr_capture, dr_shift, dr_update
  );

  modport slave (
    input  tms, tdi,
    output ir_tdo, ir_tdo_en, instruction,
    output sel_bypass, sel_idcode, sel_read, sel_write,
    output tap_state, dr_capture, dr_shift, dr_update
  );
endinterface

// File: rtl/jtag_ir_ctrl.sv
// IEEE 1149.1 TAP controller with instruction register and one-hot opcode decode.
// BYPASS is the all-ones opcode and also absorbs every undefined opcode.
module jtag_ir_ctrl #(
  parameter int                  IR_WIDTH    = 4,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP   = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] READ_OP     = IR_WIDTH'(2),
  parameter logic [IR_WIDTH-1:0] WRITE_OP    = IR_WIDTH'(4),
  parameter logic [IR_WIDTH-1:0] CAPTURE_VAL = IR_WIDTH'(1)
) (
  input logic           tck,
  input logic           trst,
  jtag_ir_ctrl_if.slave bus
);

  localparam logic [IR_WIDTH-1:0] BYPASS_OP = '1;

  if (IR_WIDTH < 2) begin : gBadWidth
    $error("jtag_ir_ctrl: IR_WIDTH must be at least 2");
  end
  if (IDCODE_OP == READ_OP || IDCODE_OP == WRITE_OP || READ_OP == WRITE_OP) begin : gDupOpcode
    $error("jtag_ir_ctrl: opcodes must be distinct");
  end
  if (IDCODE_OP == BYPASS_OP || READ_OP == BYPASS_OP || WRITE_OP == BYPASS_OP) begin : gOnesOpcode
    $error("jtag_ir_ctrl: all-ones opcode is reserved for BYPASS");
  end
  if (CAPTURE_VAL[1:0] != 2'b01) begin : gBadCapture
    $error("jtag_ir_ctrl: CAPTURE_VAL[1:0] must be 2'b01");
  end

  typedef enum logic [3:0] {
    ST_EX2_DR   = 4'h0, ST_EX1_DR   = 4'h1, ST_SH_DR    = 4'h2, ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4, ST_UP_DR    = 4'h5, ST_CAP_DR   = 4'h6, ST_SEL_DR   = 4'h7,
    ST_EX2_IR   = 4'h8, ST_EX1_IR   = 4'h9, ST_SH_IR    = 4'hA, ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC, ST_UP_IR    = 4'hD, ST_CAP_IR   = 4'hE, ST_TLR      = 4'hF
  } tapState_e;

  tapState_e           r_state;
  tapState_e           w_nextState;
  logic [IR_WIDTH-1:0] r_shift;
  logic [IR_WIDTH-1:0] r_instruction;
  logic                w_selIdcode;
  logic                w_selRead;
  logic                w_selWrite;

  always_comb begin
    w_nextState = ST_TLR;
    unique case (r_state)
      ST_TLR:      w_nextState = bus.tms ? ST_TLR      : ST_RTI;
      ST_RTI:      w_nextState = bus.tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   w_nextState = bus.tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   w_nextState = bus.tms ? ST_EX1_DR   : ST_SH_DR;
      ST_SH_DR:    w_nextState = bus.tms ? ST_EX1_DR   : ST_SH_DR;
      ST_EX1_DR:   w_nextState = bus.tms ? ST_UP_DR    : ST_PAUSE_DR;
      ST_PAUSE_DR: w_nextState = bus.tms ? ST_EX2_DR   : ST_PAUSE_DR;
      ST_EX2_DR:   w_nextState = bus.tms ? ST_UP_DR    : ST_SH_DR;
      ST_UP_DR:    w_nextState = bus.tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   w_nextState = bus.tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   w_nextState = bus.tms ? ST_EX1_IR   : ST_SH_IR;
      ST_SH_IR:    w_nextState = bus.tms ? ST_EX1_IR   : ST_SH_IR;
      ST_EX1_IR:   w_nextState = bus.tms ? ST_UP_IR    : ST_PAUSE_IR;
      ST_PAUSE_IR: w_nextState = bus.tms ? ST_EX2_IR   : ST_PAUSE_IR;
      ST_EX2_IR:   w_nextState = bus.tms ? ST_UP_IR    : ST_SH_IR;
      ST_UP_IR:    w_nextState = bus.tms ? ST_SEL_DR   : ST_RTI;
      default:     w_nextState = ST_TLR;
    endcase
  end

  // The shift register is acted on by the state being left, so the exit edge
  // out of Shift-IR still shifts and Update-IR latches the completed value.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_state       <= ST_TLR;
      r_shift       <= CAPTURE_VAL;
      r_instruction <= IDCODE_OP;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        ST_CAP_IR: r_shift       <= CAPTURE_VAL;
        ST_SH_IR:  r_shift       <= {bus.tdi, r_shift[IR_WIDTH-1:1]};
        ST_UP_IR:  r_instruction <= r_shift;
        ST_TLR:    r_instruction <= IDCODE_OP;
        default:   ;
      endcase
    end
  end

  assign w_selIdcode = (r_instruction == IDCODE_OP);
  assign w_selRead   = (r_instruction == READ_OP);
  assign w_selWrite  = (r_instruction == WRITE_OP);

  assign bus.instruction = r_instruction;
  assign bus.sel_idcode  = w_selIdcode;
  assign bus.sel_read    = w_selRead;
  assign bus.sel_write   = w_selWrite;
  assign bus.sel_bypass  = !(w_selIdcode || w_selRead || w_selWrite);

  assign bus.tap_state  = r_state;
  assign bus.ir_tdo     = r_shift[0];
  assign bus.ir_tdo_en  = (r_state == ST_SH_IR);
  assign bus.dr_capture = (r_state == ST_CAP_DR);
  assign bus.dr_shift   = (r_state == ST_SH_DR);
  assign bus.dr_update  = (r_state == ST_UP_DR);

endmodule
